// File: rtl/image_line_feeder_if.sv
// image_line_feeder bus bundle: frame-memory read port,
// pixel stream to the window controller, and frame control.
interface image_line_feeder_if #(
    parameter int ADDR_W = 18
);
    logic              i_start;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_rd;
    logic [7:0]        i_mem_rdata;
    logic [7:0]        o_pixel_data;
    logic              o_pixel_data_valid;
    logic              i_intr;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start,
        input  i_mem_rdata,
        input  i_intr,
        output o_mem_addr,
        output o_mem_rd,
        output o_pixel_data,
        output o_pixel_data_valid,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        output i_mem_rdata,
        output i_intr,
        input  o_mem_addr,
        input  o_mem_rd,
        input  o_pixel_data,
        input  o_pixel_data_valid,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/image_line_feeder.sv
// Credit-gated line streamer from frame memory to the 3x3 window controller.
// Optional FEEDER_ZERO_PAD_EN appends two zero lines after the image.
module image_line_feeder #(
    parameter int LINE_W     = 512,
    parameter int NUM_LINES  = 512,
    parameter int ADDR_W     = 18,
    parameter int MAX_CREDIT = 4
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    image_line_feeder_if.master bus
);
`ifdef FEEDER_ZERO_PAD_EN
    localparam int PAD_LINES = 2;
`else
    localparam int PAD_LINES = 0;
`endif
    localparam int TOTAL = NUM_LINES + PAD_LINES;
    localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LW = $clog2(TOTAL + 1);
    localparam int CW = $clog2(MAX_CREDIT + 1);
    localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
    localparam logic [LW-1:0] L_LAST = LW'(TOTAL - 1);
    localparam logic [LW-1:0] L_IMG_LAST = LW'(NUM_LINES - 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_CREDIT);

    typedef enum logic [1:0] {
        IDLE,
        LINE,
        WAIT,
        FLUSH
    } state_t;

    state_t            state;
    logic [XW-1:0]     x;
    logic [LW-1:0]     line;
    logic [CW-1:0]     credits;
    logic [CW-1:0]     cred_nxt;
    logic [ADDR_W-1:0] addr;
    logic              mem_rd;
    logic              vld;
    logic              vld_rd;
    logic              busy;
    logic              done;
    logic              line_end;
    logic              give;
    logic              img_end;
    logic              pad_now;
    logic              pad_nxt;

    always_comb begin
        line_end = (state == LINE) && (x == X_LAST);
        give     = bus.i_intr && (state != IDLE);
        img_end  = line_end && (line == L_IMG_LAST);
        cred_nxt = credits;
        if (give && !line_end && credits != C_MAX)
            cred_nxt = credits + CW'(1);
        else if (!give && line_end)
            cred_nxt = credits - CW'(1);
`ifdef FEEDER_ZERO_PAD_EN
        // line already points at the line about to start
        pad_now = (line > L_IMG_LAST);
        pad_nxt = (line >= L_IMG_LAST);
`else
        pad_now = 1'b0;
        pad_nxt = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            x       <= '0;
            line    <= '0;
            credits <= '0;
            addr    <= '0;
            mem_rd  <= 1'b0;
            vld     <= 1'b0;
            vld_rd  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            vld    <= (state == LINE);
            vld_rd <= mem_rd;
            done   <= 1'b0;
            if (state != IDLE)
                credits <= cred_nxt;
            // address parks on the last image pixel
            if (mem_rd && !img_end)
                addr <= addr + 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state   <= LINE;
                        x       <= '0;
                        line    <= '0;
                        addr    <= '0;
                        credits <= C_MAX;
                        mem_rd  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LINE: begin
                    if (!line_end) begin
                        x <= x + 1'b1;
                    end else begin
                        x <= '0;
                        if (line == L_LAST) begin
                            state  <= FLUSH;
                            mem_rd <= 1'b0;
                        end else begin
                            line <= line + 1'b1;
                            if (cred_nxt != '0) begin
                                mem_rd <= !pad_nxt;
                            end else begin
                                state  <= WAIT;
                                mem_rd <= 1'b0;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cred_nxt != '0) begin
                        state  <= LINE;
                        mem_rd <= !pad_now;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_mem_addr         = addr;
    assign bus.o_mem_rd           = mem_rd;
    assign bus.o_pixel_data_valid = vld;
    assign bus.o_pixel_data       = vld_rd ? bus.i_mem_rdata : 8'h00;
    assign bus.o_busy             = busy;
    assign bus.o_done             = done;
endmodule
